vx_tag_fill_ctrl: RTL and testbench
===================================

// Module: vx_tag_fill_ctrl
// PURPOSE
// Write-side driver for a cache bank's tag store: generates every tag fill/flush write the bank issues.
// After reset it walks all lines of the bank, invalidating each one.
// It then forwards memory-response fills as tag fill writes and runs full-bank invalidate walks on request.
// Sits between the bank's memory-response port / control CSR and the tag store's fill/flush/addr inputs.
// PARAMETERS
// CACHE_ID         0   cache instance id (trace only)
// BANK_ID          0   bank index (trace only)
// LINES_PER_BANK   64  lines in this bank; power of 2, >=1
// LINE_ADDR_WIDTH  26  width of line address; low LSB=$clog2(LINES_PER_BANK) bits select the line
// FILLQ_DEPTH      2   fill queue entries; power of 2, >=2
// PORTS
// clk              in   1                clock
// reset_n          in   1                asynchronous active-low reset
// stall            in   1                bank pipeline stall; a tag write takes effect only in cycles with stall=0
// flush_req_valid  in   1                request a full-bank invalidate
// flush_req_ready  out  1                flush request accepted when valid&&ready
// mrsp_valid       in   1                memory fill response present
// mrsp_addr        in   LINE_ADDR_WIDTH  line address of the fill
// mrsp_ready       out  1                fill accepted when valid&&ready
// tag_fill         out  1                tag write: mark tag_addr valid with its tag
// tag_flush        out  1                tag write: invalidate line tag_addr
// tag_addr         out  LINE_ADDR_WIDTH  line address for tag_fill/tag_flush
// busy             out  1                invalidate walk in progress; bank blocks lookups
// flush_done       out  1                one-cycle pulse on the final write of a walk
// BEHAVIOUR
// - States: RST (reset value), INIT, IDLE, FLUSH. reset_n low -> RST, walk counter=0, queue empty, asynchronously.
// - While in RST, every output is 0, except busy=1.
// - RST -> INIT on the first clk edge after reset_n rises.
// - INIT/FLUSH walk:
//   - tag_flush=1, tag_addr={'0, cnt}, busy=1.
//   - cnt increments only on cycles with stall=0.
//   - On cnt==LINES_PER_BANK-1 with stall=0: flush_done=1 that cycle, cnt wraps to 0, next state IDLE.
//   - LINES_PER_BANK=1: the walk is one non-stalled cycle.
// - Walk latency: exactly LINES_PER_BANK non-stalled cycles. The first write is in the first cycle of INIT/FLUSH.
// - IDLE, queue non-empty: tag_fill=1, tag_addr=queue head. Pop on stall=0, so one fill per non-stalled cycle.
// - IDLE, queue empty: tag_fill=tag_flush=0; tag_addr holds its last value.
// - flush_req_ready=1 only in IDLE with the queue empty, so queued fills drain before a flush.
//   - Accept -> FLUSH on the next cycle.
//   - No tag write is issued in the accept cycle.
// - flush_req_valid in any other state: held off. Requests are not dropped; the requester keeps valid high.
// - Fill queue:
//   - mrsp_ready = !full, computed from occupancy before any same-cycle pop (no full bypass).
//   - Push and pop in the same cycle keep the count unchanged. Pointers wrap modulo FILLQ_DEPTH.
//   - Fills arriving during a walk are queued, not issued. mrsp_ready drops once the queue is full.
// - tag_fill and tag_flush are never both 1.
// - Outputs are held stable while stall=1, per tag-store write rules.
// - Reset mid-walk or with fills queued discards all state; a full INIT walk restarts.
// STRUCTURE
// - Shared package vx_tag_ctrl_pkg:
//   - typedef enum {RST, INIT, IDLE, FLUSH} tag_ctrl_state_t.
//   - Localparam helper for LINE_SELECT_BITS.
// - Sub-module vx_fill_fifo: FILLQ_DEPTH x LINE_ADDR_WIDTH, async active-low reset, push/pop/full/empty.
// - Top level holds the FSM, walk counter and output mux only.
// TESTING
// 1. Reset release, LINES_PER_BANK=64, stall=0:
//    - tag_flush high 64 cycles, tag_addr 0..63, busy=1.
//    - flush_done on addr 63, then IDLE.
// 2. Stall during INIT: stall=1 for 3 cycles at cnt=10.
//    - tag_addr stays 10 for 4 cycles.
//    - Walk ends after 67 cycles total.
// 3. In IDLE: mrsp 0x100, 0x101, 0x102 back-to-back, FILLQ_DEPTH=2, stall=0.
//    - tag_fill each with matching addr, in order.
//    - mrsp_ready never drops, since pop matches push.
// 4. Fills queued (2, full), then flush_req_valid=1:
//    - Both fills issue first; flush_req_ready rises only after that.
//    - FLUSH walk of 64, then flush_done.
// 5. mrsp_valid held high during a walk:
//    - Two accepted, then mrsp_ready=0 until IDLE.
//    - Queued fills issue right after flush_done.
// 6. reset_n low at cnt=30 of FLUSH with 1 fill queued:
//    - Outputs 0 immediately, busy=1, queue empty.
//    - Fresh INIT walk from addr 0 after release.

Source files
------------

// File: rtl/vx_tag_fill_ctrl_pkg.sv
// Shared types and helpers for the tag fill/flush controller.
//   tag_ctrl_state_t  : controller state encoding (RST, INIT, IDLE, FLUSH)
//   line_select_bits  : number of line-select bits for a bank of a given size
package vx_tag_ctrl_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    INIT  = 2'd1,
    IDLE  = 2'd2,
    FLUSH = 2'd3
  } tag_ctrl_state_t;

  function automatic int line_select_bits(input int lines);
    return (lines > 1) ? $clog2(lines) : 0;
  endfunction

endpackage

// File: rtl/vx_tag_fill_ctrl_if.sv
// Handshake and tag-store write bundle of the tag fill/flush controller.
//   master : bank side (drives stall, flush request, memory fill response)
//   slave  : controller side (drives readies, tag writes, busy, flush_done)
interface vx_tag_fill_ctrl_if #(
  parameter int LINE_ADDR_WIDTH = 26
);
  logic                       stall;
  logic                       flush_req_valid;
  logic                       flush_req_ready;
  logic                       mrsp_valid;
  logic [LINE_ADDR_WIDTH-1:0] mrsp_addr;
  logic                       mrsp_ready;
  logic                       tag_fill;
  logic                       tag_flush;
  logic [LINE_ADDR_WIDTH-1:0] tag_addr;
  logic                       busy;
  logic                       flush_done;

  modport master (
    output stall, flush_req_valid, mrsp_valid, mrsp_addr,
    input  flush_req_ready, mrsp_ready, tag_fill, tag_flush, tag_addr, busy, flush_done
  );

  modport slave (
    input  stall, flush_req_valid, mrsp_valid, mrsp_addr,
    output flush_req_ready, mrsp_ready, tag_fill, tag_flush, tag_addr, busy, flush_done
  );
endinterface

// File: rtl/vx_fill_fifo.sv
// Small power-of-two FIFO holding line addresses of pending tag fills.
//   push_i/push_data_i : enqueue (caller guarantees !full_o)
//   pop_i              : dequeue head (caller guarantees !empty_o)
//   head_o             : oldest entry, valid while !empty_o
//   full_o/empty_o     : occupancy flags from the registered count
module vx_fill_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage carries data only; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vx_tag_fill_ctrl.sv
// Tag-store write driver for one cache bank.
// After reset it invalidates every line of the bank, then forwards memory fill
// responses as tag fills and runs full-bank invalidate walks on request.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : stall, flush request, memory fill response, tag writes,
//                  busy and flush_done
module vx_tag_fill_ctrl
  import vx_tag_ctrl_pkg::*;
#(
  parameter int CACHE_ID        = 0,
  parameter int BANK_ID         = 0,
  parameter int LINES_PER_BANK  = 64,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int FILLQ_DEPTH     = 2
) (
  input logic               clk,
  input logic               reset_n,
  vx_tag_fill_ctrl_if.slave bus
);
  localparam int LINE_SELECT_BITS = line_select_bits(LINES_PER_BANK);
  // A one-line bank still needs a 1-bit counter that simply stays at 0.
  localparam int CNT_W = (LINE_SELECT_BITS > 0) ? LINE_SELECT_BITS : 1;

  if (CACHE_ID < 0 || BANK_ID < 0 || LINES_PER_BANK < 1 ||
      (LINES_PER_BANK & (LINES_PER_BANK - 1)) != 0 ||
      FILLQ_DEPTH < 2 || (FILLQ_DEPTH & (FILLQ_DEPTH - 1)) != 0) begin : g_bad_param
    $error("vx_tag_fill_ctrl: illegal parameter set");
  end

  tag_ctrl_state_t            state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [LINE_ADDR_WIDTH-1:0] last_addr_q;

  logic                       fq_push, fq_pop, fq_full, fq_empty;
  logic [LINE_ADDR_WIDTH-1:0] fq_head;
  logic                       walking, walk_last;

  logic                       tag_fill, tag_flush, busy, flush_done;
  logic [LINE_ADDR_WIDTH-1:0] tag_addr;

  assign walking   = (state_q == INIT) || (state_q == FLUSH);
  assign walk_last = walking && !bus.stall && (cnt_q == CNT_W'(LINES_PER_BANK - 1));

  // Readiness is taken from occupancy before any same-cycle pop.
  assign bus.mrsp_ready      = (state_q != RST) && !fq_full;
  assign bus.flush_req_ready = (state_q == IDLE) && fq_empty;

  assign fq_push = bus.mrsp_valid && bus.mrsp_ready;
  assign fq_pop  = (state_q == IDLE) && !fq_empty && !bus.stall;

  vx_fill_fifo #(
    .DEPTH (FILLQ_DEPTH),
    .WIDTH (LINE_ADDR_WIDTH)
  ) u_fill_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (fq_push),
    .push_data_i (bus.mrsp_addr),
    .pop_i       (fq_pop),
    .full_o      (fq_full),
    .empty_o     (fq_empty),
    .head_o      (fq_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST;
      cnt_q       <= '0;
      last_addr_q <= '0;
    end else begin
      // Remember the last driven address so it can be held while idle.
      if (tag_fill || tag_flush) last_addr_q <= tag_addr;
      unique case (state_q)
        RST: state_q <= INIT;
        INIT, FLUSH: begin
          if (!bus.stall) begin
            if (walk_last) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        IDLE: if (bus.flush_req_valid && fq_empty) state_q <= FLUSH;
        default: state_q <= RST;
      endcase
    end
  end

  always_comb begin
    tag_fill   = 1'b0;
    tag_flush  = 1'b0;
    tag_addr   = last_addr_q;
    busy       = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      RST: begin
        busy     = 1'b1;
        tag_addr = '0;
      end
      INIT, FLUSH: begin
        busy       = 1'b1;
        tag_flush  = 1'b1;
        tag_addr   = LINE_ADDR_WIDTH'(cnt_q);
        flush_done = walk_last;
      end
      IDLE: begin
        if (!fq_empty) begin
          tag_fill = 1'b1;
          tag_addr = fq_head;
        end
      end
      default: ;
    endcase
  end

  assign bus.tag_fill   = tag_fill;
  assign bus.tag_flush  = tag_flush;
  assign bus.tag_addr   = tag_addr;
  assign bus.busy       = busy;
  assign bus.flush_done = flush_done;

endmodule

// File: tb/tb_vx_tag_fill_ctrl.sv
module tb_vx_tag_fill_ctrl;
  localparam int LINES = 64;
  localparam int AW    = 26;

  typedef struct packed {
    logic          fill;
    logic [AW-1:0] addr;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  vx_tag_fill_ctrl_if #(.LINE_ADDR_WIDTH(AW)) bus ();

  vx_tag_fill_ctrl #(
    .CACHE_ID        (0),
    .BANK_ID         (0),
    .LINES_PER_BANK  (LINES),
    .LINE_ADDR_WIDTH (AW),
    .FILLQ_DEPTH     (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_walk();
    for (int i = 0; i < LINES; i++)
      exp_q.push_back('{fill: 1'b0, addr: AW'(i), done: (i == LINES - 1)});
  endtask

  task automatic push_fill(input logic [AW-1:0] a);
    exp_q.push_back('{fill: 1'b1, addr: a, done: 1'b0});
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (bus.busy && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard: every tag write that takes effect is matched against the queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.tag_fill && bus.tag_flush) check("fill_and_flush", 1, 0);
      if (!bus.stall && (bus.tag_fill || bus.tag_flush)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {bus.tag_fill, bus.tag_flush, 4'h0, bus.tag_addr}, 0);
        end else begin
          automatic exp_t e = exp_q.pop_front();
          check("write_kind", {31'h0, bus.tag_fill}, {31'h0, e.fill});
          check("write_addr", 32'(bus.tag_addr), 32'(e.addr));
          check("write_done", {31'h0, bus.flush_done}, {31'h0, e.done});
        end
      end else if (bus.flush_done) begin
        check("stray_flush_done", 1, 0);
      end
    end
  end

  initial begin
    int n;
    int acc;
    logic [AW-1:0] a;

    reset_n             = 1'b0;
    bus.stall           = 1'b0;
    bus.flush_req_valid = 1'b0;
    bus.mrsp_valid      = 1'b0;
    bus.mrsp_addr       = '0;
    repeat (3) tick();

    // Reset state
    check("rst_tag_fill", {31'h0, bus.tag_fill}, 0);
    check("rst_tag_flush", {31'h0, bus.tag_flush}, 0);
    check("rst_tag_addr", 32'(bus.tag_addr), 0);
    check("rst_busy", {31'h0, bus.busy}, 1);
    check("rst_flush_done", {31'h0, bus.flush_done}, 0);
    check("rst_mrsp_ready", {31'h0, bus.mrsp_ready}, 0);
    check("rst_flush_req_ready", {31'h0, bus.flush_req_ready}, 0);

    // 1: init walk without stall: one RST cycle plus 64 writes
    push_walk();
    reset_n = 1'b1;
    wait_idle(200, n);
    check("t1_walk_cycles", n, 65);
    check("t1_sb_drained", exp_q.size(), 0);
    check("t1_hold_addr", 32'(bus.tag_addr), 63);
    check("t1_flush_req_ready", {31'h0, bus.flush_req_ready}, 1);

    // 2: stall for 3 cycles at cnt=10
    reset_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    push_walk();
    reset_n = 1'b1;
    acc = 0;
    while (bus.tag_addr != AW'(10) && acc < 40) begin
      tick();
      acc++;
    end
    check("t2_reach_10", acc, 11);
    bus.stall = 1'b1;
    check("t2_stall_addr0", 32'(bus.tag_addr), 10);
    for (int i = 1; i <= 3; i++) begin
      tick();
      acc++;
      check("t2_stall_addr", 32'(bus.tag_addr), 10);
    end
    bus.stall = 1'b0;
    tick();
    acc++;
    check("t2_after_stall", 32'(bus.tag_addr), 11);
    wait_idle(200, n);
    check("t2_walk_cycles", acc + n, 68);
    check("t2_sb_drained", exp_q.size(), 0);

    // 3: back-to-back fills in IDLE
    bus.mrsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = AW'(32'h100 + i);
      bus.mrsp_addr = a;
      check("t3_mrsp_ready", {31'h0, bus.mrsp_ready}, 1);
      push_fill(a);
      tick();
    end
    bus.mrsp_valid = 1'b0;
    repeat (2) tick();
    check("t3_sb_drained", exp_q.size(), 0);
    check("t3_idle_no_fill", {31'h0, bus.tag_fill}, 0);
    check("t3_hold_addr", 32'(bus.tag_addr), 32'h102);

    // 4: queue full, then flush request waits for the fills to drain
    bus.stall = 1'b1;
    bus.mrsp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = AW'(32'h200 + i);
      bus.mrsp_addr = a;
      check("t4_mrsp_ready", {31'h0, bus.mrsp_ready}, 1);
      push_fill(a);
      tick();
    end
    bus.mrsp_valid = 1'b0;
    check("t4_full", {31'h0, bus.mrsp_ready}, 0);
    bus.flush_req_valid = 1'b1;
    check("t4_flush_held", {31'h0, bus.flush_req_ready}, 0);
    bus.stall = 1'b0;
    n = 0;
    while (!bus.flush_req_ready && n < 10) begin
      tick();
      n++;
    end
    check("t4_drain_cycles", n, 2);
    check("t4_accept_no_write", {30'h0, bus.tag_fill, bus.tag_flush}, 0);
    push_walk();
    tick();
    bus.flush_req_valid = 1'b0;
    check("t4_busy", {31'h0, bus.busy}, 1);
    wait_idle(200, n);
    check("t4_walk_cycles", n, 64);
    check("t4_sb_drained", exp_q.size(), 0);

    // 5: fills held valid during a walk
    bus.flush_req_valid = 1'b1;
    check("t5_flush_ready", {31'h0, bus.flush_req_ready}, 1);
    push_walk();
    tick();
    bus.flush_req_valid = 1'b0;
    a = AW'(32'h300);
    bus.mrsp_addr = a;
    bus.mrsp_valid = 1'b1;
    acc = 0;
    n = 0;
    while (bus.busy && n < 200) begin
      if (bus.mrsp_ready) begin
        push_fill(a);
        acc++;
        tick();
        a = a + AW'(1);
        bus.mrsp_addr = a;
      end else begin
        tick();
      end
      n++;
    end
    bus.mrsp_valid = 1'b0;
    check("t5_accepted", acc, 2);
    check("t5_walk_cycles", n, 64);
    check("t5_fill_after_done", {31'h0, bus.tag_fill}, 1);
    check("t5_first_fill_addr", 32'(bus.tag_addr), 32'h300);
    repeat (3) tick();
    check("t5_sb_drained", exp_q.size(), 0);

    // 6: reset mid-walk with a fill queued
    bus.flush_req_valid = 1'b1;
    push_walk();
    tick();
    bus.flush_req_valid = 1'b0;
    bus.mrsp_addr = AW'(32'h400);
    bus.mrsp_valid = 1'b1;
    check("t6_mrsp_ready", {31'h0, bus.mrsp_ready}, 1);
    tick();
    bus.mrsp_valid = 1'b0;
    n = 0;
    while (bus.tag_addr != AW'(30) && n < 60) begin
      tick();
      n++;
    end
    check("t6_reach_30", 32'(bus.tag_addr), 30);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_rst_flush", {31'h0, bus.tag_flush}, 0);
    check("t6_rst_fill", {31'h0, bus.tag_fill}, 0);
    check("t6_rst_addr", 32'(bus.tag_addr), 0);
    check("t6_rst_busy", {31'h0, bus.busy}, 1);
    check("t6_rst_mrsp_ready", {31'h0, bus.mrsp_ready}, 0);
    repeat (2) tick();
    push_walk();
    reset_n = 1'b1;
    tick();
    check("t6_init_addr0", 32'(bus.tag_addr), 0);
    check("t6_init_flush", {31'h0, bus.tag_flush}, 1);
    wait_idle(200, n);
    check("t6_walk_cycles", n, 64);
    repeat (3) tick();
    check("t6_queue_empty", {31'h0, bus.tag_fill}, 0);
    check("t6_sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
